// File: rtl/fsm_pkg.sv
// Phase encoding shared by the sequencer arbiter and every phase-driven datapath block.
package fsm_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10
  } phase_t;
endpackage

// File: rtl/fsm_seq_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req after index `last`, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  // Scan farthest-to-nearest so the nearest set bit after `last` is written last and wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_seq_arbiter.sv
// Round-robin owner of the shared IDLE->S1->S2 sequencer; latches the winner's command per operation.
// Optional FSM_ARB_LOCK_EN adds a per-requester lock input that lets the owner re-grant itself.
module fsm_seq_arbiter
  import fsm_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CMD_W   = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] cmd,
`ifdef FSM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [1:0]               phase,
  output logic [CMD_W-1:0]         seq_cmd,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id
);

  phase_t              phase_q, phase_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [CMD_W-1:0]    cmd_n;
  logic [ID_W-1:0]     last, last_n, owner, owner_n;
  logic                done_n;
  logic [ID_W-1:0]     done_id_n;
  logic [ID_W-1:0]     pick_id, win_id;
  logic                pick_any, win_ok, relock_win;
  logic [CMD_W-1:0]    cmd_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd
    assign cmd_arr[i] = cmd[i*CMD_W +: CMD_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req),
    .last      (last),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

`ifdef FSM_ARB_LOCK_EN
  // Set in S2 when the owner asks to keep the sequencer; consumed by the arbitration in the done cycle.
  logic relock_q, relock_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) relock_q <= 1'b0;
    else       relock_q <= relock_n;
  end

  assign relock_win = relock_q;
  assign win_ok     = relock_q | pick_any;
  assign win_id     = relock_q ? owner : pick_id;
`else
  assign relock_win = 1'b0;
  assign win_ok     = pick_any;
  assign win_id     = pick_id;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= IDLE;
      grant   <= '0;
      seq_cmd <= '0;
      last    <= ID_W'(NUM_REQ - 1);
      owner   <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      phase_q <= phase_n;
      grant   <= grant_n;
      seq_cmd <= cmd_n;
      last    <= last_n;
      owner   <= owner_n;
      done    <= done_n;
      done_id <= done_id_n;
    end
  end

  always_comb begin
    phase_n   = phase_q;
    grant_n   = grant;
    cmd_n     = seq_cmd;
    last_n    = last;
    owner_n   = owner;
    done_n    = 1'b0;
    done_id_n = done_id;
`ifdef FSM_ARB_LOCK_EN
    relock_n  = relock_q;
`endif
    unique case (phase_q)
      IDLE: begin
`ifdef FSM_ARB_LOCK_EN
        relock_n = 1'b0;
`endif
        if (win_ok) begin
          phase_n = S1;
          grant_n = NUM_REQ'(1) << win_id;
          cmd_n   = cmd_arr[win_id];
          owner_n = win_id;
          if (!relock_win) last_n = win_id;
        end
      end
      S1: phase_n = S2;
      S2: begin
        phase_n   = IDLE;
        grant_n   = '0;
        done_n    = 1'b1;
        done_id_n = owner;
`ifdef FSM_ARB_LOCK_EN
        relock_n  = lock[owner] & req[owner];
`endif
      end
      default: begin
        phase_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  assign phase = phase_q;
  assign busy  = (phase_q != IDLE);

endmodule
